aes_cipher_sched: RTL and testbench

Shares one iterative AES-128 cipher core among NUM_REQ requesters.
- Each requester presents key, plaintext and a tag over a valid/ready handshake.
- The block arbitrates round-robin, drives the core's single-cycle load strobe and waits for the core's done pulse.
- It returns ciphertext, tag and requester ID on a valid/ready response channel.
- A watchdog converts a missing done pulse into an error response, so a stuck core never hangs a requester.

---
 rtl/aes_sched_pkg.sv | 16 +
 rtl/aes_rr_arb.sv | 36 +++
 rtl/aes_cipher_sched.sv | 134 +++++++++++++
 tb/tb_aes_cipher_sched.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types and defaults for the AES-128 cipher-core scheduler.
package aes_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BUSY,
        RESP
    } state_t;

    localparam int CORE_LATENCY = 12;
    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_TAG_W    = 4;
    localparam int DEF_TIMEOUT  = 31;

endpackage

// File: rtl/aes_rr_arb.sv
// Combinational round-robin arbiter: first valid requester at or after ptr, wrapping.
module aes_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx,
    output logic               any_valid
);

    logic          found;
    int            idx;
    logic [IW-1:0] idx_v;

    // NOTE: every variable written here gets a default first, otherwise synthesis infers latches.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = |valid;
        found     = 1'b0;
        idx       = 0;
        idx_v     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx   = (int'(ptr) + k) % NUM_REQ;
            idx_v = IW'(idx);
            if (!found && valid[idx_v]) begin
                found        = 1'b1;
                grant[idx_v] = 1'b1;
                grant_idx    = idx_v;
            end
        end
    end

endmodule

// File: rtl/aes_cipher_sched.sv
// Shares one iterative AES-128 core among NUM_REQ requesters with round-robin
// arbitration and a watchdog that turns a missing done pulse into an error response.
module aes_cipher_sched
    import aes_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*128-1:0]      req_key,
    input  logic [NUM_REQ*128-1:0]      req_text,
    input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [127:0]                rsp_text,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [TAG_W-1:0]            rsp_tag,
    output logic                        rsp_err,
    output logic                        core_ld,
    output logic [127:0]                core_key,
    output logic [127:0]                core_text_in,
    input  logic                        core_done,
    input  logic [127:0]                core_text_out,
    output logic                        busy,
    output logic                        stray_done
);

    localparam int IW   = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT);

    state_t            state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     cur_id;
    logic [TAG_W-1:0]  cur_tag;
    logic [WD_W-1:0]   wd;

    logic [NUM_REQ-1:0] grant_oh;
    logic [IW-1:0]      grant_idx;
    logic               any_valid;

    logic [127:0]      key_arr  [NUM_REQ];
    logic [127:0]      text_arr [NUM_REQ];
    logic [TAG_W-1:0]  tag_arr  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign key_arr[i]  = req_key[i*128 +: 128];
        assign text_arr[i] = req_text[i*128 +: 128];
        assign tag_arr[i]  = req_tag[i*TAG_W +: TAG_W];
    end

    aes_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .valid     (req_valid),
        .ptr       (ptr),
        .grant     (grant_oh),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    // Gated by rst so no requester sees an accept while the block is held in reset.
    assign req_ready = (rst && state == IDLE) ? grant_oh : '0;
    assign busy      = (state != IDLE);
    assign rsp_id    = cur_id;
    assign rsp_tag   = cur_tag;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            ptr          <= '0;
            cur_id       <= '0;
            cur_tag      <= '0;
            wd           <= '0;
            rsp_valid    <= 1'b0;
            rsp_text     <= '0;
            rsp_err      <= 1'b0;
            core_ld      <= 1'b0;
            core_key     <= '0;
            core_text_in <= '0;
            stray_done   <= 1'b0;
        end else begin
            core_ld <= 1'b0;
            if (core_done && state != BUSY) begin
                stray_done <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (any_valid) begin
                        core_key     <= key_arr[grant_idx];
                        core_text_in <= text_arr[grant_idx];
                        cur_tag      <= tag_arr[grant_idx];
                        cur_id       <= grant_idx;
                        core_ld      <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    wd    <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    wd <= wd + 1'b1;
                    // A done pulse in the final watchdog cycle still counts as success.
                    if (core_done) begin
                        rsp_text  <= core_text_out;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        rsp_text  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= (cur_id == IW'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cipher_sched.sv
// Scoreboard bench for aes_cipher_sched with a behavioural cipher-core model.
module tb_aes_cipher_sched;
    import aes_sched_pkg::*;

    localparam int N  = DEF_NUM_REQ;
    localparam int TW = DEF_TAG_W;
    localparam int TO = DEF_TIMEOUT;
    localparam int IW = $clog2(N);

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*128-1:0]  req_key;
    logic [N*128-1:0]  req_text;
    logic [N*TW-1:0]   req_tag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [127:0]      rsp_text;
    logic [IW-1:0]     rsp_id;
    logic [TW-1:0]     rsp_tag;
    logic              rsp_err;
    logic              core_ld;
    logic [127:0]      core_key;
    logic [127:0]      core_text_in;
    logic              core_done;
    logic [127:0]      core_text_out;
    logic              busy;
    logic              stray_done;

    aes_cipher_sched #(
        .NUM_REQ (N),
        .TAG_W   (TW),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_key       (req_key),
        .req_text      (req_text),
        .req_tag       (req_tag),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_text      (rsp_text),
        .rsp_id        (rsp_id),
        .rsp_tag       (rsp_tag),
        .rsp_err       (rsp_err),
        .core_ld       (core_ld),
        .core_key      (core_key),
        .core_text_in  (core_text_in),
        .core_done     (core_done),
        .core_text_out (core_text_out),
        .busy          (busy),
        .stray_done    (stray_done)
    );

    typedef struct {
        logic [127:0]  text;
        logic [IW-1:0] id;
        logic [TW-1:0] tag;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   gnt_log[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   gnt_cyc = 0;
    int   rsp_cnt = 0;
    int   exp_ptr = 0;
    int   core_delay = CORE_LATENCY;
    int   stray_want = 0;
    int   stray_sent = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "bench timeout");
    end

    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] t);
        if (k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
        return k ^ {t[63:0], t[127:64]} ^ 128'h5a5a_5a5a_a5a5_a5a5_0f0f_0f0f_f0f0_f0f0;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Core model: done arrives core_delay cycles after the load cycle; 0 means never.
    initial begin
        logic [127:0] m_key, m_text;
        bit           armed;
        int           cnt;
        core_done     = 1'b0;
        core_text_out = '0;
        armed         = 1'b0;
        cnt           = 0;
        forever begin
            @(posedge clk);
            #1;
            core_done = 1'b0;
            if (!rst) begin
                armed = 1'b0;
            end else if (core_ld) begin
                armed  = 1'b1;
                cnt    = 0;
                m_key  = core_key;
                m_text = core_text_in;
            end else if (armed) begin
                cnt++;
                if (core_delay != 0 && cnt == core_delay) begin
                    core_done     = 1'b1;
                    core_text_out = core_fn(m_key, m_text);
                    armed         = 1'b0;
                end
            end
            if (stray_sent < stray_want && !busy) begin
                core_done = 1'b1;
                stray_sent++;
            end
        end
    end

    // Grant observer: checks round-robin order and pushes the expected response.
    initial begin
        logic [N-1:0] expg;
        int           idx;
        int           g;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (rst && req_ready != '0) begin
                expg = '0;
                for (int k = 0; k < N; k++) begin
                    idx = (exp_ptr + k) % N;
                    if (expg == '0 && req_valid[idx]) expg[idx] = 1'b1;
                end
                check("grant", req_ready, expg);
                g = 0;
                for (int k = N - 1; k >= 0; k--) if (req_ready[k]) g = k;
                e.err  = (core_delay == 0 || core_delay > TO);
                e.text = e.err ? '0 : core_fn(req_key[g*128 +: 128], req_text[g*128 +: 128]);
                e.id   = IW'(g);
                e.tag  = req_tag[g*TW +: TW];
                sb.push_back(e);
                gnt_log.push_back(g);
                gnt_cyc = cyc;
            end
        end
    end

    // Response monitor: pops the scoreboard on every accepted response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sb.delete();
                exp_ptr = 0;
            end else if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got id %0d tag %h, required no response", rsp_id, rsp_tag);
                end else begin
                    e = sb.pop_front();
                    check("rsp_text", rsp_text, e.text);
                    check("rsp_id", rsp_id, e.id);
                    check("rsp_tag", rsp_tag, e.tag);
                    check("rsp_err", rsp_err, e.err);
                    exp_ptr = (int'(e.id) + 1) % N;
                end
                rsp_cnt++;
            end
        end
    end

    task automatic check_zero(input string pfx);
        check({pfx, "_req_ready"}, req_ready, '0);
        check({pfx, "_rsp_valid"}, rsp_valid, '0);
        check({pfx, "_rsp_text"}, rsp_text, '0);
        check({pfx, "_rsp_id"}, rsp_id, '0);
        check({pfx, "_rsp_tag"}, rsp_tag, '0);
        check({pfx, "_rsp_err"}, rsp_err, '0);
        check({pfx, "_core_ld"}, core_ld, '0);
        check({pfx, "_core_key"}, core_key, '0);
        check({pfx, "_core_text_in"}, core_text_in, '0);
        check({pfx, "_busy"}, busy, '0);
        check({pfx, "_stray_done"}, stray_done, '0);
    endtask

    task automatic set_req(input int i, input logic [127:0] k, input logic [127:0] t, input logic [TW-1:0] tg);
        req_key[i*128 +: 128] = k;
        req_text[i*128 +: 128] = t;
        req_tag[i*TW +: TW]    = tg;
    endtask

    task automatic issue(input int i, input logic [127:0] k, input logic [127:0] t, input logic [TW-1:0] tg);
        bit got = 0;
        @(posedge clk);
        #1;
        set_req(i, k, t, tg);
        req_valid[i] = 1'b1;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL issue_grant: req_ready %b, required bit %0d set", req_ready, i);
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output int ldc);
        bit got = 0;
        lat = -1;
        ldc = 0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (core_ld) ldc++;
            if (rsp_valid) begin
                got = 1;
                lat = cyc - gnt_cyc;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL rsp_wait: rsp_valid %b after 100 cycles, required 1", rsp_valid);
        end
    endtask

    task automatic drain();
        bit done = 0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy && !rsp_valid) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain: pending %0d busy %b, required 0 and 0", sb.size(), busy);
        end
    endtask

    initial begin
        int lat, ldc, bad;
        logic [127:0] s_text;
        logic [IW-1:0] s_id;
        logic [TW-1:0] s_tag;
        logic s_err;

        rst       = 1'b0;
        req_valid = '0;
        req_key   = '0;
        req_text  = '0;
        req_tag   = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // All requesters valid continuously from reset.
        for (int i = 0; i < N; i++)
            set_req(i, FIPS_KEY + 128'(i + 1), FIPS_PT ^ (128'(i + 1) << 8), TW'(8 + i));
        gnt_log.delete();
        req_valid = '1;
        for (int n = 0; n < 400 && rsp_cnt < 8; n++) begin
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        drain();
        check("rr_grant_count", gnt_log.size(), 8);
        for (int k = 0; k < 8 && k < gnt_log.size(); k++)
            check($sformatf("rr_order_%0d", k), gnt_log[k], k % N);

        // FIPS-197 single request.
        issue(0, FIPS_KEY, FIPS_PT, 4'h5);
        wait_rsp(lat, ldc);
        check("fips_latency", lat, 14);
        check("fips_core_ld_cycles", ldc, 1);
        check("fips_core_key_held", core_key, FIPS_KEY);
        check("fips_core_text_held", core_text_in, FIPS_PT);
        drain();

        // Back-pressure with another requester waiting.
        rsp_ready = 1'b0;
        issue(1, 128'h1, 128'h2, 4'h3);
        set_req(3, 128'h33, 128'h44, 4'hc);
        req_valid[3] = 1'b1;
        wait_rsp(lat, ldc);
        s_text = rsp_text;
        s_id   = rsp_id;
        s_tag  = rsp_tag;
        s_err  = rsp_err;
        bad    = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_text !== s_text || rsp_id !== s_id || rsp_tag !== s_tag ||
                rsp_err !== s_err || req_ready !== '0 || core_ld !== 1'b0) bad++;
        end
        check("bp_unstable_cycles", bad, 0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_next_grant", req_ready, 4'b1000);
        @(posedge clk);
        #1;
        req_valid[3] = 1'b0;
        wait_rsp(lat, ldc);
        check("bp_followup_latency", lat, 14);
        drain();

        // Watchdog timeout, then a normal request.
        core_delay = 0;
        issue(2, 128'hdead, 128'hbeef, 4'h7);
        wait_rsp(lat, ldc);
        check("timeout_latency", lat, TO + 2);
        drain();
        core_delay = CORE_LATENCY;
        issue(3, 128'h1234, 128'h5678, 4'h9);
        wait_rsp(lat, ldc);
        check("post_timeout_latency", lat, 14);
        drain();

        // Done in the last watchdog cycle wins over the timeout.
        core_delay = TO;
        issue(0, 128'hcafe, 128'hf00d, 4'ha);
        wait_rsp(lat, ldc);
        check("coincident_latency", lat, TO + 2);
        drain();
        core_delay = CORE_LATENCY;

        // Stray done in IDLE.
        @(posedge clk);
        #1;
        stray_want = 1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("stray_done_set", stray_done, 1'b1);
        check("stray_busy", busy, 1'b0);

        // Reset during BUSY abandons the request.
        issue(1, 128'h77, 128'h88, 4'h1);
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_busy", busy, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_zero("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("post_reset_no_rsp", rsp_valid, 1'b0);
        check("post_reset_idle", busy, 1'b0);
        issue(2, 128'h99, 128'haa, 4'h2);
        wait_rsp(lat, ldc);
        check("post_reset_latency", lat, 14);
        drain();

        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
